// File: rtl/vga_pkg.sv
// Shared timing constants, types and helpers for the bouncing-box pixel stage.
// The box position/direction update rule lives here so both axes use identical logic.
package vga_pkg;

  localparam int H_ACTIVE_START = 408;
  localparam int V_ACTIVE_START = 42;
  localparam int H_ACTIVE       = 1280;
  localparam int V_ACTIVE       = 1024;
  localparam int H_TOTAL        = 1688;
  localparam int V_TOTAL        = 1066;
  localparam int BOX_SIZE       = 64;
  localparam int STEP           = 4;
  localparam int XMAX           = H_ACTIVE - BOX_SIZE;
  localparam int YMAX           = V_ACTIVE - BOX_SIZE;

  typedef logic [2:0] colour_idx_t;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } motion_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef struct packed {
    logic [10:0] pos;
    dir_t        dir;
    logic        bounce;
  } axis_t;

  // Stage-1 pixel decisions carried to the colour stage.
  typedef struct packed {
    logic        active;
    logic        in_box;
    logic        border;
    logic        grid;
    colour_idx_t colour;
    logic        hsync;
    logic        vsync;
  } pix_flags_t;

  localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_GREY  = '{r: 4'h3, g: 4'h3, b: 4'h3};

  function automatic rgb_t colour_decode(input colour_idx_t idx);
    rgb_t c;
    c.r = idx[2] ? 4'hF : 4'h0;
    c.g = idx[1] ? 4'hF : 4'h0;
    c.b = idx[0] ? 4'hF : 4'h0;
    return c;
  endfunction

  // Index 0 would be an invisible black box, so the sequence skips it.
  function automatic colour_idx_t colour_next(input colour_idx_t idx);
    return (idx == 3'd7) ? 3'd1 : idx + 3'd1;
  endfunction

  // One STEP along an axis, clamping to [0, max] and reversing on contact.
  function automatic axis_t axis_step(input logic [10:0] pos, input dir_t dir,
                                      input logic [10:0] max);
    axis_t res;
    res.pos    = pos;
    res.dir    = dir;
    res.bounce = 1'b0;
    if (dir == POS) begin
      if (({1'b0, pos} + 12'(STEP)) >= {1'b0, max}) begin
        res.pos    = max;
        res.dir    = NEG;
        res.bounce = 1'b1;
      end else begin
        res.pos = pos + 11'(STEP);
      end
    end else begin
      if ({1'b0, pos} <= 12'(STEP)) begin
        res.pos    = 11'd0;
        res.dir    = POS;
        res.bounce = 1'b1;
      end else begin
        res.pos = pos - 11'(STEP);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_box_motion.sv
// Box motion: walks IDLE -> UPD_X -> UPD_Y once per frame start, moving the box
// and advancing its colour at most once per frame when either axis bounces.
module vga_box_motion
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        frame_start,
  output logic [10:0] box_x,
  output logic [10:0] box_y,
  output colour_idx_t colour_idx
);

  motion_state_t state_q, state_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  dir_t          dx_q, dx_d, dy_q, dy_d;
  colour_idx_t   colour_q, colour_d;
  logic          en_q, en_d;
  logic          bounce_x_q, bounce_x_d;
  axis_t         x_step, y_step;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_UPD_X;
      ST_UPD_X: state_d = ST_UPD_Y;
      ST_UPD_Y: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    colour_d   = colour_q;
    en_d       = en_q;
    bounce_x_d = bounce_x_q;
    x_step     = axis_step(x_q, dx_q, 11'(XMAX));
    y_step     = axis_step(y_q, dy_q, 11'(YMAX));
    case (state_q)
      // ENABLE is captured once so a frame never half-moves.
      ST_IDLE: if (frame_start) en_d = enable;
      ST_UPD_X: begin
        bounce_x_d = en_q & x_step.bounce;
        if (en_q) begin
          x_d  = x_step.pos;
          dx_d = x_step.dir;
        end
      end
      ST_UPD_Y: begin
        if (en_q) begin
          y_d  = y_step.pos;
          dy_d = y_step.dir;
          if (bounce_x_q || y_step.bounce) colour_d = colour_next(colour_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      x_q        <= '0;
      y_q        <= '0;
      dx_q       <= POS;
      dy_q       <= POS;
      colour_q   <= 3'd1;
      en_q       <= 1'b0;
      bounce_x_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      colour_q   <= colour_d;
      en_q       <= en_d;
      bounce_x_q <= bounce_x_d;
    end
  end

  assign box_x      = x_q;
  assign box_y      = y_q;
  assign colour_idx = colour_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Two-stage pixel colour pipeline: stage 1 classifies the pixel, stage 2 picks RGB.
// Sync bits ride the same two stages so they stay aligned with the colour.
module vga_bounce_box
  import vga_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [10:0] HPOS,
  input  logic [10:0] VPOS,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HSYNC,
  output logic        VSYNC
);

  localparam pix_flags_t FLAGS_RESET = '{active: 1'b0, in_box: 1'b0, border: 1'b0,
                                         grid: 1'b0, colour: 3'd0, hsync: 1'b1,
                                         vsync: 1'b1};

  logic        frame_start;
  logic [10:0] box_x, box_y;
  colour_idx_t colour_idx;
  logic [10:0] ax, ay;
  pix_flags_t  flags_q, flags_d;
  rgb_t        pix_q, pix_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;

  assign frame_start = (HPOS == 11'd0) && (VPOS == 11'd0);

  vga_box_motion u_motion (
    .clk        (CLK),
    .srst       (RST),
    .enable     (ENABLE),
    .frame_start(frame_start),
    .box_x      (box_x),
    .box_y      (box_y),
    .colour_idx (colour_idx)
  );

  always_comb begin
    flags_d = FLAGS_RESET;
    ax      = HPOS - 11'(H_ACTIVE_START);
    ay      = VPOS - 11'(V_ACTIVE_START);
    flags_d.active = (HPOS >= 11'(H_ACTIVE_START)) && (HPOS < 11'(H_ACTIVE_START + H_ACTIVE)) &&
                     (VPOS >= 11'(V_ACTIVE_START)) && (VPOS < 11'(V_ACTIVE_START + V_ACTIVE));
    // 12-bit compare keeps box_x + BOX_SIZE from wrapping.
    flags_d.in_box = ({1'b0, ax} >= {1'b0, box_x}) &&
                     ({1'b0, ax} <  ({1'b0, box_x} + 12'(BOX_SIZE))) &&
                     ({1'b0, ay} >= {1'b0, box_y}) &&
                     ({1'b0, ay} <  ({1'b0, box_y} + 12'(BOX_SIZE)));
    flags_d.border = (ax == 11'd0) || (ax == 11'(H_ACTIVE - 1)) ||
                     (ay == 11'd0) || (ay == 11'(V_ACTIVE - 1));
    flags_d.grid   = (ax[6:0] == 7'd0) || (ay[6:0] == 7'd0);
    flags_d.colour = colour_idx;
    flags_d.hsync  = HSYNC_IN;
    flags_d.vsync  = VSYNC_IN;
  end

  always_comb begin
    pix_d   = RGB_BLACK;
    hsync_d = flags_q.hsync;
    vsync_d = flags_q.vsync;
    if (flags_q.active) begin
      if (flags_q.in_box)      pix_d = colour_decode(flags_q.colour);
      else if (flags_q.border) pix_d = RGB_WHITE;
      else if (flags_q.grid)   pix_d = RGB_GREY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= FLAGS_RESET;
      pix_q   <= RGB_BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      pix_q   <= pix_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign R     = pix_q.r;
  assign G     = pix_q.g;
  assign B     = pix_q.b;
  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;

endmodule
